// File: rtl/ram_param_clr.sv
// Single-port-address RAM with registered read data and a clear sweep that zeroes every word.
// Reads: one-cycle latency; accesses during a sweep (or on a clr edge) are dropped and flagged.
module ram_param_clr #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              r,
    input  logic              w,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  D,
    input  logic              clr,
    output logic [WIDTH-1:0]  o,
    output logic              valid,
    output logic              busy,
    output logic              drop
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]    o_q, o_d;
    logic                valid_q, valid_d;
    logic                drop_q, drop_d;

    logic [WIDTH-1:0]    mem [DEPTH];
    logic                acc;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_wa;
    logic [WIDTH-1:0]    mem_wd;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        o_d     = o_q;
        acc     = (state_q == RUN) && !clr;
        valid_d = acc && r;
        drop_d  = (r || w) && !acc;
        mem_we  = 1'b0;
        mem_wa  = addr;
        mem_wd  = D;

        if (state_q == INIT) begin
            if (clr) begin
                cnt_d = '0;
            end else begin
                mem_we = 1'b1;
                mem_wa = cnt_q;
                mem_wd = '0;
                cnt_d  = cnt_q + ADDR_W'(1);
                if (cnt_q == '1) begin
                    state_d = RUN;
                end
            end
        end else if (clr) begin
            state_d = INIT;
            cnt_d   = '0;
        end else begin
            // Read uses the pre-edge contents, so a same-address write is read-first.
            if (r) begin
                o_d = mem[addr];
            end
            mem_we = w;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem[mem_wa] <= mem_wd;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= INIT;
            cnt_q   <= '0;
            o_q     <= '0;
            valid_q <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            o_q     <= o_d;
            valid_q <= valid_d;
            drop_q  <= drop_d;
        end
    end

    assign o     = o_q;
    assign valid = valid_q;
    assign drop  = drop_q;
    assign busy  = (state_q == INIT);

endmodule

// File: tb/tb_ram_param_clr.sv
// Bench for ram_param_clr: directed scenarios plus random traffic against a behavioural model,
// and a reduced-size instance to check the sweep length scales with depth.
module tb_ram_param_clr;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        r = 1'b0, w = 1'b0, clr = 1'b0;
    logic [5:0]  addr = '0;
    logic [15:0] D = '0;
    logic [15:0] o;
    logic        valid, busy, drop;

    logic        s_rst = 1'b0;
    logic        s_r = 1'b0, s_w = 1'b0, s_clr = 1'b0;
    logic [2:0]  s_addr = '0;
    logic [7:0]  s_D = '0;
    logic [7:0]  s_o;
    logic        s_valid, s_busy, s_drop;

    always #5 clk = ~clk;

    ram_param_clr dut (
        .clk(clk), .rst(rst), .r(r), .w(w), .addr(addr), .D(D), .clr(clr),
        .o(o), .valid(valid), .busy(busy), .drop(drop)
    );

    ram_param_clr #(.WIDTH(8), .ADDR_W(3)) dut_s (
        .clk(clk), .rst(s_rst), .r(s_r), .w(s_w), .addr(s_addr), .D(s_D), .clr(s_clr),
        .o(s_o), .valid(s_valid), .busy(s_busy), .drop(s_drop)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model: memory is cleared as a whole when a sweep starts (its contents are
    // unobservable until the sweep ends), and the sweep is tracked as a count of busy edges left.
    logic [15:0] m_mem [64];
    logic [15:0] m_o;
    logic        m_valid, m_drop;
    int          m_left;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        foreach (m_mem[i]) m_mem[i] = '0;
        m_o     = '0;
        m_valid = 1'b0;
        m_drop  = 1'b0;
        m_left  = 64;
    endtask

    task automatic step();
        @(posedge clk);
        if (m_left > 0) begin
            m_valid = 1'b0;
            m_drop  = r | w;
            if (clr) m_left = 64;
            else     m_left = m_left - 1;
        end else if (clr) begin
            m_valid = 1'b0;
            m_drop  = r | w;
            foreach (m_mem[i]) m_mem[i] = '0;
            m_left  = 64;
        end else begin
            m_drop  = 1'b0;
            m_valid = r;
            if (r) m_o = m_mem[addr];
            if (w) m_mem[addr] = D;
        end
        #1;
        chk("o", o, m_o);
        chk("valid", valid, m_valid);
        chk("drop", drop, m_drop);
        chk("busy", busy, m_left > 0);
    endtask

    task automatic acc(input logic rr, input logic ww, input logic [5:0] a, input logic [15:0] d);
        r = rr; w = ww; addr = a; D = d;
        step();
        r = 1'b0; w = 1'b0;
    endtask

    task automatic clr_pulse();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 200) begin
            step();
            n++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end

    initial begin
        int n;
        #1;
        rst = 1'b1;
        s_rst = 1'b1;
        #1;
        chk("rst_o", o, 0);
        chk("rst_valid", valid, 0);
        chk("rst_drop", drop, 0);
        chk("rst_busy", busy, 1);
        chk("s_rst_busy", s_busy, 1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();

        count_busy(n);
        chk("busy_len_init", n, 64);

        acc(1'b1, 1'b0, 6'd0, '0);
        chk("rd0_o", o, 0);
        chk("rd0_valid", valid, 1);
        acc(1'b1, 1'b0, 6'd31, '0);
        chk("rd31_valid", valid, 1);
        acc(1'b1, 1'b0, 6'd63, '0);
        chk("rd63_o", o, 0);

        acc(1'b0, 1'b1, 6'd31, 16'd256);
        acc(1'b1, 1'b0, 6'd31, '0);
        chk("wr31_o", o, 256);
        chk("wr31_valid", valid, 1);
        acc(1'b0, 1'b1, 6'd21, 16'd64);
        acc(1'b1, 1'b0, 6'd21, '0);
        chk("wr21_o", o, 64);
        acc(1'b1, 1'b1, 6'd21, 16'd7);
        chk("rw_same_old", o, 64);
        acc(1'b1, 1'b0, 6'd21, '0);
        chk("rw_same_new", o, 7);
        step();
        chk("idle_valid", valid, 0);
        chk("idle_o_hold", o, 7);

        clr_pulse();
        chk("clr_busy", busy, 1);
        acc(1'b0, 1'b1, 6'd3, 16'd5);
        chk("busy_drop", drop, 1);
        step();
        chk("drop_pulse", drop, 0);
        count_busy(n);
        chk("busy_len_clr", n, 62);
        acc(1'b1, 1'b0, 6'd21, '0);
        chk("clr21_o", o, 0);
        acc(1'b1, 1'b0, 6'd31, '0);
        chk("clr31_o", o, 0);
        acc(1'b1, 1'b0, 6'd3, '0);
        chk("dropped_wr3", o, 0);

        clr_pulse();
        repeat (10) step();
        clr_pulse();
        count_busy(n);
        chk("busy_len_repulse", n, 64);

        for (int i = 0; i < 800; i++) begin
            r    = 1'($urandom_range(0, 1));
            w    = 1'($urandom_range(0, 1));
            addr = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'(21 + 10 * $urandom_range(0, 2));
            D    = 16'($urandom);
            clr  = ($urandom_range(0, 199) == 0);
            step();
        end
        r = 1'b0; w = 1'b0; clr = 1'b0;
        count_busy(n);

        acc(1'b0, 1'b1, 6'd31, 16'd256);
        acc(1'b1, 1'b0, 6'd31, '0);
        chk("pre_arst_o", o, 256);
        chk("pre_arst_valid", valid, 1);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_o", o, 0);
        chk("arst_valid", valid, 0);
        chk("arst_busy", busy, 1);
        chk("arst_drop", drop, 0);
        #1;
        rst = 1'b0;
        model_reset();
        count_busy(n);
        chk("busy_len_arst", n, 64);
        acc(1'b1, 1'b0, 6'd31, '0);
        chk("arst_rd31", o, 0);

        @(posedge clk);
        #1;
        s_rst = 1'b0;
        n = 0;
        while (s_busy && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("s_busy_len", n, 8);
        s_r = 1'b1; s_addr = 3'd5;
        @(posedge clk);
        #1;
        s_r = 1'b0;
        chk("s_rd5_o", s_o, 0);
        chk("s_rd5_valid", s_valid, 1);
        s_w = 1'b1; s_addr = 3'd2; s_D = 8'hA5;
        @(posedge clk);
        #1;
        s_w = 1'b0; s_r = 1'b1;
        @(posedge clk);
        #1;
        s_r = 1'b0;
        chk("s_rd2_o", s_o, 8'hA5);
        chk("s_rd2_drop", s_drop, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
